// File: rtl/sdc_write_sched_if.sv
// Handshake and bus bundle between the SD write scheduler and its environment.
// master = scheduler side, slave = source / SD engine / controller side.
interface sdc_write_sched_if;
  logic        start;
  logic [31:0] start_block;
  logic [15:0] n_blocks;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        cmd_valid;
  logic [31:0] cmd_addr;
  logic        cmd_ready;
  logic [7:0]  wr_byte;
  logic        wr_valid;
  logic        wr_ready;
  logic        blk_done;
  logic        blk_err;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] blocks_left;

  modport master (
    input  start, start_block, n_blocks, byte_in, byte_valid, cmd_ready, wr_ready,
           blk_done, blk_err,
    output byte_ready, cmd_valid, cmd_addr, wr_byte, wr_valid, busy, done, err, blocks_left
  );

  modport slave (
    output start, start_block, n_blocks, byte_in, byte_valid, cmd_ready, wr_ready,
           blk_done, blk_err,
    input  byte_ready, cmd_valid, cmd_addr, wr_byte, wr_valid, busy, done, err, blocks_left
  );
endinterface

// File: rtl/sdc_write_sched.sv
// Multi-block SD write scheduler: issues one write command per block and streams its bytes.
// Optional WAIT timeout enabled by defining SDC_WRITE_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for start
// CMD    | single-block write command offered to the SD engine
// DATA   | byte pass-through until BLOCK_BYTES transferred
// WAIT   | waiting for the engine's block result
// FIN    | one-cycle finish, done pulses if no error
module sdc_write_sched #(
  parameter int BLOCK_BYTES = 512,
  parameter int TIMEOUT_CYC = 65535
) (
  input logic                clk,
  input logic                reset,
  sdc_write_sched_if.master  bus
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_DATA, S_WAIT, S_FIN} state_t;

  if (BLOCK_BYTES < 1 || BLOCK_BYTES > 1023 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535)
  begin : g_param_chk
    $error("sdc_write_sched: BLOCK_BYTES or TIMEOUT_CYC out of range");
  end

  localparam logic [9:0] LAST_BYTE = 10'(BLOCK_BYTES - 1);

  state_t      state;
  logic [31:0] cur_addr;
  logic [15:0] blocks_left_q;
  logic [9:0]  byte_cnt;
  logic        err_q;
  logic        in_data;
  logic        xfer;

`ifdef SDC_WRITE_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] tmo_cnt;
`endif

  assign in_data = (state == S_DATA);
  assign xfer    = in_data && bus.byte_valid && bus.wr_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      cur_addr      <= '0;
      blocks_left_q <= '0;
      byte_cnt      <= '0;
      err_q         <= 1'b0;
`ifdef SDC_WRITE_TIMEOUT_EN
      tmo_cnt       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            cur_addr      <= bus.start_block;
            blocks_left_q <= bus.n_blocks;
            err_q         <= 1'b0;
            state         <= (bus.n_blocks == 16'd0) ? S_FIN : S_CMD;
          end
        end
        S_CMD: begin
          if (bus.cmd_ready) begin
            byte_cnt <= '0;
            state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (xfer) begin
            byte_cnt <= byte_cnt + 10'd1;
            if (byte_cnt == LAST_BYTE) begin
              state <= S_WAIT;
`ifdef SDC_WRITE_TIMEOUT_EN
              tmo_cnt <= '0;
`endif
            end
          end
        end
        S_WAIT: begin
          // An error on the same cycle as blk_done takes priority; blocks_left is kept.
          if (bus.blk_err) begin
            err_q <= 1'b1;
            state <= S_FIN;
          end else if (bus.blk_done) begin
            blocks_left_q <= blocks_left_q - 16'd1;
            cur_addr      <= cur_addr + 32'd1;
            state         <= (blocks_left_q == 16'd1) ? S_FIN : S_CMD;
          end
`ifdef SDC_WRITE_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            err_q <= 1'b1;
            state <= S_FIN;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
`endif
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = (state != S_IDLE);
  assign bus.cmd_valid   = (state == S_CMD);
  assign bus.cmd_addr    = cur_addr;
  assign bus.wr_byte     = in_data ? bus.byte_in : 8'h00;
  assign bus.wr_valid    = in_data && bus.byte_valid;
  assign bus.byte_ready  = in_data && bus.wr_ready;
  assign bus.done        = (state == S_FIN) && !err_q;
  assign bus.err         = err_q;
  assign bus.blocks_left = blocks_left_q;

endmodule

// File: doc/sdc_write_sched.md
SDC_WRITE_SCHED -- requirements
Module: sdc_write_sched

Interface
REQ-001 The block SHALL have parameter BLOCK_BYTES, default 512, bytes per SD block.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 65535, max cycles spent in WAIT.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port start, input, 1: begin a multi-block transfer; sampled only in IDLE.
REQ-006 Port start_block, input, 32: first block address.
REQ-007 Port n_blocks, input, 16: number of blocks to write; 0 means complete immediately.
REQ-008 Port byte_in, input, 8, paired with byte_valid (input, 1) and byte_ready (output, 1): source byte stream.
REQ-009 Port cmd_valid, output, 1, with cmd_addr (output, 32) and cmd_ready (input, 1): single-block write command to the SD engine.
REQ-010 Port wr_byte, output, 8, with wr_valid (output, 1) and wr_ready (input, 1): data byte to the SD engine.
REQ-011 Port blk_done, input, 1, and blk_err, input, 1: one-cycle pulses giving the SD engine's block result.
REQ-012 Port busy, output, 1: high in any state other than IDLE.
REQ-013 Port done, output, 1: one-cycle pulse on the cycle of a successful finish.
REQ-014 Port err, output, 1: sticky error flag; cleared on an accepted start.
REQ-015 Port blocks_left, output, 16: number of blocks not yet acknowledged.

Function
REQ-016 States SHALL be IDLE, CMD, DATA, WAIT, FIN.
REQ-017 IDLE with start=1 SHALL perform all of the following:
  - latch cur_addr=start_block and blocks_left=n_blocks;
  - clear err;
  - go to FIN if n_blocks=0, otherwise go to CMD.
REQ-018 CMD SHALL assert cmd_valid with cmd_addr=cur_addr, and go to DATA on the cycle where cmd_valid and cmd_ready are both high.
REQ-019 DATA SHALL pass bytes through combinationally:
  - wr_byte=byte_in;
  - wr_valid=byte_valid;
  - byte_ready=wr_ready.
  One byte transfers per cycle where byte_valid and wr_ready are both high.
REQ-020 byte_ready and wr_valid SHALL be 0 outside DATA.
REQ-021 A 10-bit byte counter SHALL do the following:
  - clear on entry to DATA;
  - increment on each transfer;
  - go to WAIT on the transfer that makes it reach BLOCK_BYTES.
REQ-022 In WAIT, blk_done SHALL do the following:
  - decrement blocks_left;
  - increment cur_addr by 1, with 32-bit wrap from 0xFFFFFFFF to 0;
  - go to FIN if blocks_left was 1, otherwise go to CMD.
REQ-023 In WAIT, blk_err SHALL set err and go to FIN, leaving blocks_left unchanged.
REQ-024 If blk_done and blk_err arrive on the same cycle, blk_err SHALL win.
REQ-025 FIN SHALL last one cycle and return to IDLE; done SHALL pulse in FIN only if err=0.
REQ-026 blk_done and blk_err outside WAIT SHALL be ignored.
REQ-027 start while busy SHALL be ignored.
REQ-028 cmd_addr SHALL be registered; all handshake outputs SHALL be decoded from the state register with no extra latency.

Reset
REQ-029 Assertion of reset SHALL immediately, regardless of clk, do the following:
  - force state IDLE;
  - clear cur_addr, blocks_left, the byte counter, err, done, cmd_valid and busy.
REQ-030 Reset asserted mid-transfer SHALL abandon the transfer with no done pulse.
REQ-031 The first edge after reset deassertion SHALL be able to accept start.

Configuration
REQ-032 Macro SDC_WRITE_TIMEOUT_EN SHALL control a WAIT-state timeout.
REQ-033 With SDC_WRITE_TIMEOUT_EN defined, the timeout SHALL behave as follows:
  - a 16-bit counter clears on entry to WAIT and increments each WAIT cycle;
  - reaching TIMEOUT_CYC without blk_done or blk_err sets err and goes to FIN;
  - blk_done on the same cycle as the timeout wins.
REQ-034 Without SDC_WRITE_TIMEOUT_EN, WAIT SHALL wait indefinitely and no timeout counter SHALL exist.

Verification
REQ-035 Single block: set start_block=0x10, n_blocks=1, always-ready sink, 512 bytes, blk_done. Required:
  - exactly one cmd with addr 0x10;
  - 512 wr transfers, with data equal to the source data;
  - done pulses once;
  - busy falls after FIN.
REQ-036 Multi-block with address wrap: set start_block=0xFFFFFFFE, n_blocks=3. Required:
  - cmd_addr sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000;
  - blocks_left steps 3, 2, 1, 0.
REQ-037 Backpressure: randomly toggle byte_valid and wr_ready, and hold cmd_ready low for 5 cycles. Required:
  - no byte lost or duplicated;
  - cmd_valid held stable until accepted.
REQ-038 Error: pulse blk_err and blk_done together on block 2 of 4. Required:
  - err=1;
  - no done pulse;
  - blocks_left=3;
  - return to IDLE;
  - the next start clears err.
REQ-039 Reset mid-DATA: assert reset at byte 100. Required:
  - all outputs 0 immediately;
  - a new start writes from the new start_block.
REQ-040 Zero blocks and timeout:
  - n_blocks=0 SHALL produce FIN and done with no cmd.
  - With SDC_WRITE_TIMEOUT_EN and TIMEOUT_CYC=16, withholding blk_done SHALL set err after 16 WAIT cycles.
